// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one registered sprite ROM between two tank requesters.
// Each return is tagged and routed back to its requester. Out-of-range reads are flagged. Contention is counted per frame.
module sprite_rom_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 24,
    parameter int ROM_DEPTH = 10275,
    parameter int ROM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic              frame_start,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              oob_err,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_q,
    output logic [15:0]       conflict_cnt,
    output logic              prio_state
);

    // Handshake: a read is accepted in any cycle where req and gnt are both high.
    // The requester must hold addr while req is high and gnt is low.
    // Returns have no back-pressure: rvalid is a one-cycle pulse that the requester must take.

    localparam logic [31:0] DEPTH_U = 32'(ROM_DEPTH);
    localparam int          LAST    = ROM_LAT - 1;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_t;

    prio_t             state;
    prio_t             state_nxt;
    logic              eff_prio1;
    logic              any_gnt;
    logic              in_range;
    logic [ADDR_W-1:0] last_addr;
    logic              conflict;

    logic [ROM_LAT-1:0] tag_vld;
    logic [ROM_LAT-1:0] tag_id;
    logic [ROM_LAT-1:0] tag_oob;
    logic               ret_vld;
    logic               ret_id;
    logic               ret_oob;

    assign prio_state = state;
    assign conflict   = req0 & req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRIO0;
        end else begin
            state <= state_nxt;
        end
    end

    // line_start overrides the stored priority in favour of requester 0.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rom_addr  = last_addr;
        rom_rden  = 1'b0;
        eff_prio1 = (state == PRIO1) && !line_start;
        if (rst_n) begin
            if (req0 && (!req1 || !eff_prio1)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            rom_addr  = addr0;
            state_nxt = PRIO1;
        end else if (gnt1) begin
            rom_addr  = addr1;
            state_nxt = PRIO0;
        end else if (line_start) begin
            state_nxt = PRIO0;
        end
        any_gnt  = gnt0 | gnt1;
        in_range = 32'(rom_addr) < DEPTH_U;
        rom_rden = any_gnt && in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
        end else if (any_gnt) begin
            last_addr <= rom_addr;
        end
    end

    // Tag stages track each issued read until its ROM word arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
            tag_oob <= '0;
        end else begin
            tag_vld[0] <= any_gnt;
            tag_id[0]  <= gnt1;
            tag_oob[0] <= any_gnt && !in_range;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
                tag_oob[i] <= tag_oob[i-1];
            end
        end
    end

    assign ret_vld = tag_vld[LAST];
    assign ret_id  = tag_id[LAST];
    assign ret_oob = tag_oob[LAST];

    // Output registers form the final tag stage; rom_q lines up with ret_* here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            oob_err <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= ret_vld && !ret_id;
            rvalid1 <= ret_vld && ret_id;
            oob_err <= ret_vld && ret_oob;
            if (ret_vld && !ret_id) begin
                rdata0 <= ret_oob ? '0 : rom_q;
            end
            if (ret_vld && ret_id) begin
                rdata1 <= ret_oob ? '0 : rom_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (frame_start) begin
            conflict_cnt <= {15'd0, conflict};
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table, reset/saturation sequences and random traffic
// checked against a cycle-level behavioural model with a return queue.
module tb_sprite_rom_arbiter;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 24;
    localparam int ROM_DEPTH = 10275;
    localparam int ROM_LAT   = 1;
    localparam int RET_LAT   = ROM_LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              line_start = 1'b0;
    logic              frame_start = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              oob_err;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rden;
    logic [DATA_W-1:0] rom_q = '0;
    logic [15:0]       conflict_cnt;
    logic              prio_state;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(ROM_DEPTH), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .frame_start(frame_start),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .oob_err(oob_err),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
        .conflict_cnt(conflict_cnt), .prio_state(prio_state)
    );

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        rom_word = {a[7:0] ^ 8'hC3, a[13:6] + 8'h11, ~a[7:0]};
    endfunction

    // Registered ROM with one cycle of latency.
    always @(posedge clk) begin
        if (rom_rden) rom_q <= rom_word(rom_addr);
    end

    // ---------------- reference model ----------------
    int                m_prio;
    int                m_cnt;
    logic [ADDR_W-1:0] m_last;
    logic [DATA_W-1:0] m_rd0;
    logic [DATA_W-1:0] m_rd1;
    logic              m_g0;
    logic              m_g1;
    logic [26:0]       exp_q[$];   // {valid, id, oob, data}, one entry per cycle

    task automatic model_reset();
        m_prio = 0;
        m_cnt  = 0;
        m_last = '0;
        m_rd0  = '0;
        m_rd1  = '0;
        m_g0   = 1'b0;
        m_g1   = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic drive_cycle(input logic fs, input logic ls, input logic r0, input logic r1,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        logic [26:0]       e;
        logic              g_any;
        int                g_id;
        int                eff;
        logic [ADDR_W-1:0] ga;
        @(negedge clk);
        frame_start = fs;
        line_start  = ls;
        req0        = r0;
        req1        = r1;
        addr0       = a0;
        addr1       = a1;
        #1;
        if (exp_q.size() == RET_LAT) e = exp_q.pop_front();
        else e = '0;
        if (e[26] && !e[25]) m_rd0 = e[24] ? '0 : e[23:0];
        if (e[26] && e[25])  m_rd1 = e[24] ? '0 : e[23:0];
        chk("rvalid0", 32'(rvalid0), 32'(e[26] && !e[25]));
        chk("rvalid1", 32'(rvalid1), 32'(e[26] && e[25]));
        chk("oob_err", 32'(oob_err), 32'(e[26] && e[24]));
        chk("rdata0", 32'(rdata0), 32'(m_rd0));
        chk("rdata1", 32'(rdata1), 32'(m_rd1));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        chk("prio_state", 32'(prio_state), 32'(m_prio));

        eff   = ls ? 0 : m_prio;
        g_any = r0 | r1;
        g_id  = (r0 && r1) ? eff : (r1 ? 1 : 0);
        ga    = g_any ? ((g_id == 1) ? a1 : a0) : m_last;
        m_g0  = g_any && (g_id == 0);
        m_g1  = g_any && (g_id == 1);
        chk("gnt0", 32'(gnt0), 32'(m_g0));
        chk("gnt1", 32'(gnt1), 32'(m_g1));
        chk("rom_addr", 32'(rom_addr), 32'(ga));
        chk("rom_rden", 32'(rom_rden), 32'(g_any && (int'(ga) < ROM_DEPTH)));

        if (g_any) begin
            m_prio = 1 - g_id;
            m_last = ga;
        end else if (ls) begin
            m_prio = 0;
        end
        if (fs) m_cnt = (r0 && r1) ? 1 : 0;
        else if (r0 && r1 && m_cnt < 65535) m_cnt++;
        exp_q.push_back({g_any, (g_id == 1), g_any && (int'(ga) >= ROM_DEPTH), rom_word(ga)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req0        = 1'b1;
        req1        = 1'b1;
        addr0       = 14'd77;
        addr1       = 14'd99;
        line_start  = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_gnt0", 32'(gnt0), 32'd0);
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_rvalid0", 32'(rvalid0), 32'd0);
            chk("rst_rvalid1", 32'(rvalid1), 32'd0);
            chk("rst_rdata0", 32'(rdata0), 32'd0);
            chk("rst_rdata1", 32'(rdata1), 32'd0);
            chk("rst_oob_err", 32'(oob_err), 32'd0);
            chk("rst_rom_addr", 32'(rom_addr), 32'd0);
            chk("rst_rom_rden", 32'(rom_rden), 32'd0);
            chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
            @(negedge clk);
        end
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              fs;
        logic              ls;
        logic              r0;
        logic              r1;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic              g0;
        logic              g1;
        logic              rden;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int fs, input int ls, input int r0, input int r1, input int a0,
                           input int a1, input int g0, input int g1, input int rden,
                           input int addr, input int cnt);
        vec_t v;
        v.fs = 1'(fs);   v.ls = 1'(ls);   v.r0 = 1'(r0);   v.r1 = 1'(r1);
        v.a0 = 14'(a0);  v.a1 = 14'(a1);
        v.g0 = 1'(g0);   v.g1 = 1'(g1);   v.rden = 1'(rden);
        v.addr = 14'(addr); v.cnt = 16'(cnt);
        vecs.push_back(v);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 14'($urandom_range(10270, 16383));
        return 14'($urandom_range(0, 10274));
    endfunction

    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic              rr0;
    logic              rr1;

    initial begin
        model_reset();
        //      fs ls r0 r1   a0     a1   g0 g1 rden addr  cnt
        add_vec(0, 0, 1, 0,   13,     0,  1, 0, 1,    13,  0);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0,    13,  0);
        add_vec(0, 1, 0, 0,    0,     0,  0, 0, 0,    13,  0);
        add_vec(0, 0, 1, 1,  100,   200,  1, 0, 1,   100,  0);
        add_vec(0, 0, 1, 1,  100,   200,  0, 1, 1,   200,  1);
        add_vec(0, 0, 1, 1,  100,   200,  1, 0, 1,   100,  2);
        add_vec(0, 0, 1, 1,  100,   200,  0, 1, 1,   200,  3);
        add_vec(0, 0, 1, 1,  100,   200,  1, 0, 1,   100,  4);
        add_vec(0, 0, 1, 1,  100,   200,  0, 1, 1,   200,  5);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0,   200,  6);
        add_vec(0, 0, 1, 0,    5,     0,  1, 0, 1,     5,  6);
        add_vec(0, 1, 1, 1,  100,   200,  1, 0, 1,   100,  6);
        add_vec(0, 0, 1, 1,  100,   200,  0, 1, 1,   200,  7);
        add_vec(0, 0, 0, 1,    0, 10275,  0, 1, 0, 10275,  8);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0, 10275,  8);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0, 10275,  8);
        add_vec(0, 0, 1, 0, 10274,    0,  1, 0, 1, 10274,  8);
        add_vec(1, 0, 0, 0,    0,     0,  0, 0, 0, 10274,  8);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0, 10274,  0);
        add_vec(0, 1, 0, 1,    0,     0,  0, 1, 1,     0,  0);
        add_vec(0, 0, 0, 0,    0,     0,  0, 0, 0,     0,  0);

        do_reset();

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].fs, vecs[i].ls, vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1);
            chk("tbl_gnt0", 32'(gnt0), 32'(vecs[i].g0));
            chk("tbl_gnt1", 32'(gnt1), 32'(vecs[i].g1));
            chk("tbl_rom_rden", 32'(rom_rden), 32'(vecs[i].rden));
            chk("tbl_rom_addr", 32'(rom_addr), 32'(vecs[i].addr));
            chk("tbl_conflict_cnt", 32'(conflict_cnt), 32'(vecs[i].cnt));
        end

        // A grant in flight when reset hits must never return.
        drive_cycle(0, 0, 1, 0, 14'd7, 14'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, 0, 14'd0, 14'd0);
            chk("post_rst_rvalid0", 32'(rvalid0), 32'd0);
        end

        // Random traffic; a losing requester holds its request and address.
        rr0 = 1'b0;
        rr1 = 1'b0;
        ra0 = '0;
        ra1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(rr0 && !m_g0)) begin
                rr0 = ($urandom_range(0, 2) != 0);
                ra0 = rand_addr();
            end
            if (!(rr1 && !m_g1)) begin
                rr1 = ($urandom_range(0, 2) != 0);
                ra1 = rand_addr();
            end
            drive_cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0),
                        rr0, rr1, ra0, ra1);
        end

        // Saturation, then frame_start colliding with a conflict.
        drive_cycle(1, 0, 0, 0, 14'd0, 14'd0);
        for (int i = 0; i < 65540; i++) begin
            drive_cycle(0, 0, 1, 1, 14'd300, 14'd10275);
        end
        chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
        drive_cycle(1, 0, 1, 1, 14'd300, 14'd10275);
        drive_cycle(0, 0, 0, 0, 14'd0, 14'd0);
        chk("fs_with_conflict", 32'(conflict_cnt), 32'd1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 14'd0, 14'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
